unpacked_serializer: RTL and testbench
======================================

// Module: unpacked_serializer
//
// PURPOSE
// Reader-side width converter for unpacked element streams. Accepts one full vector of
// IN_NUM elements in a single valid/ready beat. Replays it downstream as IN_NUM/OUT_NUM
// consecutive chunks of OUT_NUM elements each. Sits after an unpacked FIFO where a
// narrower consumer (e.g. an OUT_NUM-lane compute unit) drains a wide buffered vector.
//
// PARAMETERS
// DATA_WIDTH  8  bit width of one element
// IN_NUM      8  elements per input vector
// OUT_NUM     2  elements per output chunk
//                Must satisfy 1 <= OUT_NUM <= IN_NUM and IN_NUM % OUT_NUM == 0.
//                Elaboration error otherwise.
// (local) BEATS = IN_NUM/OUT_NUM
//         CNT_W = max(1, $clog2(BEATS))
//
// PORTS
// clk             in   1                    clock
// rst             in   1                    reset; one clock, reset is asynchronous and active-low
// data_in         in   DATA_WIDTH x IN_NUM  input vector, unpacked [IN_NUM-1:0]
// data_in_valid   in   1                    input vector valid
// data_in_ready   out  1                    block can take a vector this cycle
// data_out        out  DATA_WIDTH x OUT_NUM output chunk, unpacked [OUT_NUM-1:0]
// data_out_valid  out  1                    chunk valid
// data_out_ready  in   1                    downstream accepts chunk
// data_out_last   out  1                    current chunk is the final chunk (index BEATS-1) of its vector
//
// BEHAVIOUR
// - State: IDLE / SEND (1 bit), beat counter cnt[CNT_W-1:0], holding buffer buf[IN_NUM].
// - Reset (rst=0, async): state=IDLE, cnt=0, data_out_valid=0.
//   buf is not reset; data_out is don't-care while data_out_valid=0.
//   data_in_ready is gated to 0 while rst=0.
// - data_in_ready = rst & (state==IDLE | (cnt==BEATS-1 & data_out_ready)). Combinational.
// - Input handshake (data_in_valid & data_in_ready at edge N):
//   buf <= data_in, cnt <= 0, state <= SEND.
//   First chunk is valid from cycle N+1, so latency is 1 cycle.
// - data_out[j] = buf[cnt*OUT_NUM + j] for j in 0..OUT_NUM-1.
//   This is a combinational mux from registers; chunk k carries input elements
//   k*OUT_NUM .. k*OUT_NUM+OUT_NUM-1.
// - data_out_valid = (state==SEND). data_out_last = (state==SEND) & (cnt==BEATS-1).
// - Output handshake (data_out_valid & data_out_ready):
//   - cnt < BEATS-1: cnt <= cnt+1.
//   - cnt == BEATS-1 and a new input handshakes in the same cycle:
//     reload buf, cnt <= 0, stay in SEND. No bubble.
//   - cnt == BEATS-1 and no new input: state <= IDLE, cnt <= 0.
// - Stall: while data_out_valid & !data_out_ready, data_out, data_out_last and cnt hold.
//   data_in_ready = 0 in this condition.
// - Throughput: one vector per BEATS cycles under continuous valid/ready.
//   BEATS==1 degenerates to a 1-entry pipeline register with full throughput.
// - data_in_valid is ignored when data_in_ready=0. The upstream holds data per protocol.
// - Reset mid-vector: the remaining chunks are discarded.
//   After rst deasserts, the block is IDLE and accepts a new vector on the first edge.
// - cnt never exceeds BEATS-1. Its wrap to 0 happens only at the last beat.
//
// TESTING
// 1. Single vector, defaults. Input {0..7} (element i = i), out_ready=1.
//    -> 4 chunks on cycles N+1..N+4: {0,1},{2,3},{4,5},{6,7}.
//    -> last=1 only on {6,7}. valid=0 at N+5.
// 2. Back-to-back vectors. Inputs {0..7} then {8..15}, in_valid=1, out_ready=1.
//    -> 8 consecutive valid chunks with no gap. in_ready=1 exactly on the 4th chunk of vector 1.
// 3. Backpressure. out_ready=0 for 3 cycles while chunk {2,3} is presented.
//    -> data_out holds {2,3}, in_ready=0. Sequence resumes {4,5},{6,7} with nothing lost or duplicated.
// 4. Reset mid-vector. Assert rst=0 asynchronously after chunk {2,3}.
//    -> valid=0 immediately, in_ready=0.
//    -> After release, new vector {20..27} yields {20,21} first.
// 5. Parameter corners:
//    OUT_NUM=8 -> 1 chunk per vector, last=1 always, full throughput.
//    OUT_NUM=1 -> 8 single-element chunks.
//    Both cases: random valid/ready, scoreboard matches flattened input order.
// 6. Idle handling. in_valid=0 for 10 cycles after reset.
//    -> valid=0, in_ready=1 throughout. No spurious output.

Source files
------------

// File: rtl/unpacked_serializer_if.sv
// unpacked_serializer_if: wide-vector input / narrow-chunk output handshake bundle
interface unpacked_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_NUM = 8,
    parameter int OUT_NUM = 2
);
    logic [DATA_WIDTH-1:0] data_in [IN_NUM-1:0];
    logic data_in_valid;
    logic data_in_ready;
    logic [DATA_WIDTH-1:0] data_out [OUT_NUM-1:0];
    logic data_out_valid;
    logic data_out_ready;
    logic data_out_last;
    modport master (
        output data_in, data_in_valid, data_out_ready,
        input data_in_ready, data_out, data_out_valid, data_out_last
    );
    modport slave (
        input data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, data_out_last
    );
endinterface

// File: rtl/unpacked_serializer.sv
// unpacked_serializer: replays one IN_NUM-element vector as IN_NUM/OUT_NUM chunks of OUT_NUM elements
module unpacked_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_NUM = 8,
    parameter int OUT_NUM = 2
) (
    input logic clk,
    input logic rst,
    unpacked_serializer_if.slave bus
);
    localparam int BEATS = IN_NUM / OUT_NUM;
    localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int IDX_W = IN_NUM > 1 ? $clog2(IN_NUM) : 1;
    if (OUT_NUM < 1 || OUT_NUM > IN_NUM || IN_NUM % OUT_NUM != 0) begin : g_bad_params
        $error("unpacked_serializer: OUT_NUM must lie in 1..IN_NUM and divide IN_NUM");
    end
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [DATA_WIDTH-1:0] hold_buf [IN_NUM-1:0];
    logic last_beat, in_fire, out_fire;
    assign last_beat = cnt == CNT_W'(BEATS - 1);
    assign out_fire = state == SEND && bus.data_out_ready;
    assign in_fire = bus.data_in_valid && bus.data_in_ready;
    // A new vector may enter when idle or as the final chunk of the current one leaves
    assign bus.data_in_ready = rst && (state == IDLE || (last_beat && bus.data_out_ready));
    assign bus.data_out_valid = state == SEND;
    assign bus.data_out_last = state == SEND && last_beat;
    for (genvar j = 0; j < OUT_NUM; j++) begin : g_lane
        assign bus.data_out[j] = hold_buf[IDX_W'(int'(cnt) * OUT_NUM + j)];
    end
    // A fresh vector always restarts at chunk 0; otherwise step on each accepted chunk
    always_comb begin
        state_nx = in_fire ? SEND : (out_fire && last_beat) ? IDLE : state;
        cnt_nx = (in_fire || (out_fire && last_beat)) ? '0 : out_fire ? cnt + CNT_W'(1) : cnt;
    end
    // Control state; an async reset drops any partially replayed vector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
        end
    end
    // Capture the whole vector on the input handshake; contents only matter while sending
    always_ff @(posedge clk) begin
        if (in_fire) hold_buf <= bus.data_in;
    end
endmodule

// File: tb/tb_unpacked_serializer.sv
// tb_unpacked_serializer: directed table plus randomized scoreboard runs for OUT_NUM 2, 8 and 1
module tb_unpacked_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errors = 0;
    int checks = 0;
    int done = 0;
    bit go = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit iv;
        logic [7:0] base;
        bit ordy;
        bit ev;
        bit er;
        bit el;
        logic [7:0] e0;
    } vec_t;
    vec_t tbl[$];

    unpacked_serializer_if #(.DATA_WIDTH(8), .IN_NUM(8), .OUT_NUM(2)) dbus ();
    unpacked_serializer #(.DATA_WIDTH(8), .IN_NUM(8), .OUT_NUM(2)) dut (.clk(clk), .rst(rst), .bus(dbus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit iv, input logic [7:0] base, input bit ordy,
                       input bit ev, input bit er, input bit el, input logic [7:0] e0);
        vec_t r;
        r.iv = iv;
        r.base = base;
        r.ordy = ordy;
        r.ev = ev;
        r.er = er;
        r.el = el;
        r.e0 = e0;
        tbl.push_back(r);
    endtask

    task automatic drive(input bit iv, input logic [7:0] base, input bit ordy);
        @(negedge clk);
        dbus.data_in_valid = iv;
        for (int e = 0; e < 8; e++) dbus.data_in[e] = base + 8'(e);
        dbus.data_out_ready = ordy;
        #1;
    endtask

    task automatic expect_out(input string tag, input bit ev, input bit er, input bit el, input logic [7:0] e0);
        chk({tag, "_valid"}, dbus.data_out_valid, ev);
        chk({tag, "_ready"}, dbus.data_in_ready, er);
        chk({tag, "_last"}, dbus.data_out_last, el);
        if (ev) begin
            chk({tag, "_d0"}, dbus.data_out[0], e0);
            chk({tag, "_d1"}, dbus.data_out[1], e0 + 8'd1);
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int ON = k == 0 ? 2 : k == 1 ? 8 : 1;
        unpacked_serializer_if #(.DATA_WIDTH(8), .IN_NUM(8), .OUT_NUM(ON)) bus ();
        unpacked_serializer #(.DATA_WIDTH(8), .IN_NUM(8), .OUT_NUM(ON)) u (.clk(clk), .rst(rst), .bus(bus));
        initial begin : drv
            logic [7:0] q[$];
            int pos;
            bit acc, ev, er, in_hs, out_hs;
            bus.data_in_valid = 1'b0;
            bus.data_out_ready = 1'b0;
            for (int e = 0; e < 8; e++) bus.data_in[e] = '0;
            pos = 0;
            acc = 1'b0;
            wait (go);
            repeat (300) begin
                @(negedge clk);
                if (!bus.data_in_valid || acc) begin
                    bus.data_in_valid = $urandom_range(0, 1) == 1;
                    for (int e = 0; e < 8; e++) bus.data_in[e] = 8'($urandom);
                end
                bus.data_out_ready = $urandom_range(0, 3) != 0;
                #1;
                ev = q.size() != 0;
                er = !ev || (q.size() == ON && bus.data_out_ready);
                chk($sformatf("rand%0d_valid", ON), bus.data_out_valid, ev);
                chk($sformatf("rand%0d_ready", ON), bus.data_in_ready, er);
                if (ev) begin
                    chk($sformatf("rand%0d_last", ON), bus.data_out_last, pos + ON == 8);
                    for (int j = 0; j < ON; j++) chk($sformatf("rand%0d_data%0d", ON, j), bus.data_out[j], q[j]);
                end
                in_hs = bus.data_in_valid && er;
                out_hs = ev && bus.data_out_ready;
                @(posedge clk);
                if (out_hs) begin
                    repeat (ON) void'(q.pop_front());
                    pos = (pos + ON) % 8;
                end
                if (in_hs) for (int e = 0; e < 8; e++) q.push_back(bus.data_in[e]);
                acc = in_hs;
            end
            @(negedge clk);
            bus.data_in_valid = 1'b0;
            done++;
        end
    end

    initial begin
        dbus.data_in_valid = 1'b0;
        dbus.data_out_ready = 1'b0;
        for (int e = 0; e < 8; e++) dbus.data_in[e] = '0;
        #12;
        chk("reset_valid", dbus.data_out_valid, 0);
        chk("reset_ready", dbus.data_in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(0, 8'h00, 1);
            expect_out("idle", 0, 1, 0, 8'h00);
        end
        add(1, 8'h00, 1, 0, 1, 0, 8'h00);
        add(0, 8'h00, 1, 1, 0, 0, 8'h00);
        add(0, 8'h00, 1, 1, 0, 0, 8'h02);
        add(0, 8'h00, 1, 1, 0, 0, 8'h04);
        add(0, 8'h00, 1, 1, 1, 1, 8'h06);
        add(0, 8'h00, 1, 0, 1, 0, 8'h00);
        add(1, 8'h00, 1, 0, 1, 0, 8'h00);
        add(1, 8'h08, 1, 1, 0, 0, 8'h00);
        add(1, 8'h08, 1, 1, 0, 0, 8'h02);
        add(1, 8'h08, 1, 1, 0, 0, 8'h04);
        add(1, 8'h08, 1, 1, 1, 1, 8'h06);
        add(0, 8'h00, 1, 1, 0, 0, 8'h08);
        add(0, 8'h00, 1, 1, 0, 0, 8'h0a);
        add(0, 8'h00, 1, 1, 0, 0, 8'h0c);
        add(0, 8'h00, 1, 1, 1, 1, 8'h0e);
        add(0, 8'h00, 1, 0, 1, 0, 8'h00);
        add(1, 8'h00, 1, 0, 1, 0, 8'h00);
        add(0, 8'h00, 1, 1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 0, 0, 8'h02);
        add(0, 8'h00, 0, 1, 0, 0, 8'h02);
        add(0, 8'h00, 0, 1, 0, 0, 8'h02);
        add(0, 8'h00, 1, 1, 0, 0, 8'h02);
        add(0, 8'h00, 1, 1, 0, 0, 8'h04);
        add(0, 8'h00, 1, 1, 1, 1, 8'h06);
        add(0, 8'h00, 1, 0, 1, 0, 8'h00);
        add(1, 8'h30, 1, 0, 1, 0, 8'h00);
        add(0, 8'h00, 1, 1, 0, 0, 8'h30);
        add(0, 8'h00, 1, 1, 0, 0, 8'h32);
        add(0, 8'h00, 1, 1, 0, 0, 8'h34);
        add(1, 8'h40, 0, 1, 0, 1, 8'h36);
        add(1, 8'h40, 1, 1, 1, 1, 8'h36);
        add(0, 8'h00, 1, 1, 0, 0, 8'h40);
        add(0, 8'h00, 1, 1, 0, 0, 8'h42);
        add(0, 8'h00, 1, 1, 0, 0, 8'h44);
        add(0, 8'h00, 1, 1, 1, 1, 8'h46);
        add(0, 8'h00, 1, 0, 1, 0, 8'h00);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].base, tbl[i].ordy);
            expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].er, tbl[i].el, tbl[i].e0);
        end
        drive(1, 8'h50, 1);
        expect_out("rm_acc", 0, 1, 0, 8'h00);
        drive(0, 8'h00, 1);
        expect_out("rm_c0", 1, 0, 0, 8'h50);
        drive(0, 8'h00, 1);
        expect_out("rm_c1", 1, 0, 0, 8'h52);
        #2 rst = 1'b0;
        #1;
        expect_out("rm_rst", 0, 0, 0, 8'h00);
        drive(1, 8'd20, 1);
        expect_out("rm_hold", 0, 0, 0, 8'h00);
        rst = 1'b1;
        drive(0, 8'h00, 1);
        expect_out("rm_new0", 1, 0, 0, 8'd20);
        drive(0, 8'h00, 1);
        expect_out("rm_new1", 1, 0, 0, 8'd22);
        drive(0, 8'h00, 1);
        expect_out("rm_new2", 1, 0, 0, 8'd24);
        drive(0, 8'h00, 1);
        expect_out("rm_new3", 1, 1, 1, 8'd26);
        drive(0, 8'h00, 1);
        expect_out("rm_end", 0, 1, 0, 8'h00);
        go = 1'b1;
        for (int c = 0; c < 3000 && done < 3; c++) @(posedge clk);
        chk("rand_done", done, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
